// File: rtl/b_redirect_merge_if.sv
// Request bundle between NUM_CH producers, the merge and its two destinations.
// slave modport is the merge side, master modport is the producer/consumer side.
interface b_redirect_merge_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 33
);
    logic [NUM_CH-1:0]        i_drive;
    logic [NUM_CH*DATA_W-1:0] i_data;
    logic [NUM_CH-1:0]        o_free;
    logic                     o_drive0;
    logic [DATA_W-1:0]        o_data0;
    logic                     i_freeNext0;
    logic                     o_drive1;
    logic [DATA_W-1:0]        o_data1;
    logic                     i_freeNext1;
    logic [NUM_CH-1:0]        o_grant;

    modport slave (
        input  i_drive, i_data, i_freeNext0, i_freeNext1,
        output o_free, o_drive0, o_data0, o_drive1, o_data1, o_grant
    );

    modport master (
        output i_drive, i_data, i_freeNext0, i_freeNext1,
        input  o_free, o_drive0, o_data0, o_drive1, o_data1, o_grant
    );
endinterface

// File: rtl/b_redirect_merge.sv
// Purpose: N-channel buffered merge of redirect requests, routed to table-update (data==0) or correction (data!=0).
// Latency: 1 cycle from input accept edge to o_driveD; arbitration fixed-priority, or round-robin with B_REDIRECT_RR_EN.
// Backpressure: o_free drops when a channel FIFO is full; a stalled destination only stalls heads routed to it.
module b_redirect_merge #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 33,
    parameter int DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst,
    b_redirect_merge_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CH_W  = $clog2(NUM_CH);

    logic [DATA_W-1:0] mem   [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wptr  [NUM_CH];
    logic [PTR_W-1:0]  rptr  [NUM_CH];
    logic [CNT_W-1:0]  count [NUM_CH];
    logic [DATA_W-1:0] head  [NUM_CH];

    logic [NUM_CH-1:0] free, push, elig, grant;
    logic              vld0, vld1;
    logic [DATA_W-1:0] dat0, dat1;
    logic              load0_ok, load1_ok;
    logic              gnt_any, gnt_dest;
    logic [CH_W-1:0]   gnt_idx;
    logic [DATA_W-1:0] gnt_dat;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A destination register accepts a new entry when empty or draining this same edge.
    always_comb begin
        load0_ok = !vld0 || bus.i_freeNext0;
        load1_ok = !vld1 || bus.i_freeNext1;
        for (int c = 0; c < NUM_CH; c++) begin
            head[c] = mem[c][rptr[c]];
            free[c] = rst && (count[c] < CNT_W'(DEPTH));
            push[c] = bus.i_drive[c] && free[c];
            elig[c] = (count[c] != '0) && ((head[c] == '0) ? load0_ok : load1_ok);
        end
    end

`ifdef B_REDIRECT_RR_EN
    logic [CH_W-1:0] rr_ptr;

    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gnt_any && elig[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_any && elig[i]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(i);
            end
        end
    end
`endif

    always_comb begin
        grant          = '0;
        grant[gnt_idx] = gnt_any;
        gnt_dat        = head[gnt_idx];
        gnt_dest       = |gnt_dat;
    end

    // Storage is not reset: only pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) mem[c][wptr[c]] <= bus.i_data[c*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr[c]  <= '0;
                rptr[c]  <= '0;
                count[c] <= '0;
            end
            vld0 <= 1'b0;
            vld1 <= 1'b0;
            dat0 <= '0;
            dat1 <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c])  wptr[c] <= inc_ptr(wptr[c]);
                if (grant[c]) rptr[c] <= inc_ptr(rptr[c]);
                if (push[c] && !grant[c])      count[c] <= count[c] + 1'b1;
                else if (!push[c] && grant[c]) count[c] <= count[c] - 1'b1;
            end
            if (gnt_any && !gnt_dest) begin
                vld0 <= 1'b1;
                dat0 <= gnt_dat;
            end else if (bus.i_freeNext0) begin
                vld0 <= 1'b0;
            end
            if (gnt_any && gnt_dest) begin
                vld1 <= 1'b1;
                dat1 <= gnt_dat;
            end else if (bus.i_freeNext1) begin
                vld1 <= 1'b0;
            end
        end
    end

    assign bus.o_free   = free;
    assign bus.o_grant  = grant;
    assign bus.o_drive0 = vld0;
    assign bus.o_data0  = dat0;
    assign bus.o_drive1 = vld1;
    assign bus.o_data1  = dat1;
endmodule

// File: tb/tb_b_redirect_merge.sv
// Directed bench for b_redirect_merge; input/output monitors feed a per-destination scoreboard.
module tb_b_redirect_merge;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 33;
    localparam int DEPTH  = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [DATA_W-1:0] exp0[$];
    logic [DATA_W-1:0] exp1[$];
    logic [1:0]        exp_g [4];

    b_redirect_merge_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    b_redirect_merge #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic drv, input logic [DATA_W-1:0] d);
        bus.i_drive[c] = drv;
        bus.i_data[c*DATA_W +: DATA_W] = d;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && (exp0.size() != 0 || exp1.size() != 0); i++) tick();
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d/%0d outputs outstanding, expected 0/0", name, exp0.size(), exp1.size());
        end
    endtask

    // Scoreboard: accepted inputs are queued per destination, transfers are popped in order.
    always @(negedge clk) begin : monitor
        logic [DATA_W-1:0] d;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.i_drive[c] && bus.o_free[c]) begin
                    d = bus.i_data[c*DATA_W +: DATA_W];
                    if (d == '0) exp0.push_back(d);
                    else         exp1.push_back(d);
                end
            end
            if (bus.o_drive0 && bus.i_freeNext0) begin
                checks++;
                if (exp0.size() == 0) begin
                    errors++;
                    $display("FAIL out0_unexpected: got 0x%0h expected no transfer", bus.o_data0);
                end else begin
                    d = exp0.pop_front();
                    if (bus.o_data0 !== d) begin
                        errors++;
                        $display("FAIL out0_data: got 0x%0h expected 0x%0h", bus.o_data0, d);
                    end
                end
            end
            if (bus.o_drive1 && bus.i_freeNext1) begin
                checks++;
                if (exp1.size() == 0) begin
                    errors++;
                    $display("FAIL out1_unexpected: got 0x%0h expected no transfer", bus.o_data1);
                end else begin
                    d = exp1.pop_front();
                    if (bus.o_data1 !== d) begin
                        errors++;
                        $display("FAIL out1_data: got 0x%0h expected 0x%0h", bus.o_data1, d);
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
`ifdef B_REDIRECT_RR_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
        rst             = 1'b0;
        bus.i_drive     = '0;
        bus.i_data      = '0;
        bus.i_freeNext0 = 1'b1;
        bus.i_freeNext1 = 1'b1;
        repeat (3) tick();
        chk("rst_free",   64'(bus.o_free),   64'h0);
        chk("rst_drive0", 64'(bus.o_drive0), 64'h0);
        chk("rst_drive1", 64'(bus.o_drive1), 64'h0);
        chk("rst_data0",  64'(bus.o_data0),  64'h0);
        chk("rst_data1",  64'(bus.o_data1),  64'h0);
        chk("rst_grant",  64'(bus.o_grant),  64'h0);
        rst = 1'b1;
        #1;
        chk("free_after_release", 64'(bus.o_free), 64'h3);
        tick();

        // single non-zero request on ch1
        set_ch(1, 1'b1, 33'h0_0000_1000);
        tick();
        set_ch(1, 1'b0, '0);
        chk("t1_grant",     64'(bus.o_grant),  64'h2);
        chk("t1_drive1_pre", 64'(bus.o_drive1), 64'h0);
        tick();
        chk("t1_drive1", 64'(bus.o_drive1), 64'h1);
        chk("t1_data1",  64'(bus.o_data1),  64'h1000);
        chk("t1_drive0", 64'(bus.o_drive0), 64'h0);
        chk("t1_grant_idle", 64'(bus.o_grant), 64'h0);
        tick();
        chk("t1_drive1_done", 64'(bus.o_drive1), 64'h0);

        // zero request on ch0 goes to table-update
        set_ch(0, 1'b1, '0);
        tick();
        set_ch(0, 1'b0, '0);
        chk("t2_grant", 64'(bus.o_grant), 64'h1);
        tick();
        chk("t2_drive0", 64'(bus.o_drive0), 64'h1);
        chk("t2_data0",  64'(bus.o_data0),  64'h0);
        tick();
        chk("t2_drive0_done", 64'(bus.o_drive0), 64'h0);

        // correction stalled: fill ch0, zero request on ch1 bypasses it
        bus.i_freeNext1 = 1'b0;
        set_ch(0, 1'b1, 33'h1_0000_00A1);
        tick();
        chk("t3_grant_a", 64'(bus.o_grant), 64'h1);
        chk("t3_free_a",  64'(bus.o_free[0]), 64'h1);
        set_ch(0, 1'b1, 33'h0_0000_00B2);
        tick();
        chk("t3_drive1_a", 64'(bus.o_drive1), 64'h1);
        chk("t3_data1_a",  64'(bus.o_data1),  64'h1_0000_00A1);
        chk("t3_grant_stall", 64'(bus.o_grant), 64'h0);
        set_ch(0, 1'b1, 33'h0_0000_00C3);
        tick();
        chk("t3_free_full", 64'(bus.o_free[0]), 64'h0);
        set_ch(0, 1'b1, 33'h1_ABCD_00D4);
        set_ch(1, 1'b1, '0);
        tick();
        set_ch(1, 1'b0, '0);
        chk("t3_grant_ch1", 64'(bus.o_grant), 64'h2);
        chk("t3_free_still_full", 64'(bus.o_free[0]), 64'h0);
        tick();
        chk("t3_drive0", 64'(bus.o_drive0), 64'h1);
        chk("t3_data0",  64'(bus.o_data0),  64'h0);
        chk("t3_data1_held", 64'(bus.o_data1), 64'h1_0000_00A1);

        // release correction: full FIFO refuses during the pop cycle, accepts next
        bus.i_freeNext1 = 1'b1;
        #1;
        chk("t5_free_pop_cycle",  64'(bus.o_free[0]), 64'h0);
        chk("t5_grant_pop_cycle", 64'(bus.o_grant),   64'h1);
        tick();
        chk("t5_free_next", 64'(bus.o_free[0]), 64'h1);
        chk("t5_data1_b",   64'(bus.o_data1),   64'h0_0000_00B2);
        tick();
        set_ch(0, 1'b0, '0);
        drain("t5_drain");

        // mid-operation reset with three buffered requests
        bus.i_freeNext1 = 1'b0;
        set_ch(0, 1'b1, 33'h0_0000_0E01);
        tick();
        set_ch(0, 1'b1, 33'h0_0000_0E02);
        tick();
        set_ch(0, 1'b1, 33'h0_0000_0E03);
        set_ch(1, 1'b1, 33'h0_0000_0F01);
        tick();
        set_ch(0, 1'b0, '0);
        set_ch(1, 1'b0, '0);
        chk("t6_drive1_before", 64'(bus.o_drive1), 64'h1);
        rst = 1'b0;
        #1;
        exp0.delete();
        exp1.delete();
        chk("t6_drive1_rst", 64'(bus.o_drive1), 64'h0);
        chk("t6_data1_rst",  64'(bus.o_data1),  64'h0);
        chk("t6_free_rst",   64'(bus.o_free),   64'h0);
        chk("t6_grant_rst",  64'(bus.o_grant),  64'h0);
        tick();
        rst = 1'b1;
        bus.i_freeNext1 = 1'b1;
        #1;
        chk("t6_free_release", 64'(bus.o_free), 64'h3);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_no_stale", 64'({bus.o_drive0, bus.o_drive1, bus.o_grant}), 64'h0);
        end

        // arbitration with both channels continuously busy
        set_ch(0, 1'b1, 33'h1_0000_0100);
        set_ch(1, 1'b1, '0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_grant_%0d", k), 64'(bus.o_grant), 64'(exp_g[k]));
            set_ch(0, 1'b1, 33'h1_0000_0101 + 33'(k));
            tick();
        end
        set_ch(0, 1'b0, '0);
        set_ch(1, 1'b0, '0);
        drain("t4_drain");

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/b_redirect_merge.md
# b_redirect_merge

Parametrised, clocked successor to the branch-process request merge: collects update/redirect requests from `NUM_CH` producers (backend corrections, predictor self-clear), buffers each channel in a small FIFO, arbitrates one request per cycle and routes it by content to either the table-update destination (data == 0) or the PC-correction destination (data != 0). Sits between the producers and the predictor tables / `bcorrect` stage of the branch-process logic, replacing the two-input merge plus conditional fork with a buffered N-input version.

## Interface
- `NUM_CH`, 2, number of request channels (≥2); channel 0 is the highest fixed priority.
- `DATA_W`, 33, request width (counter bit + 32-bit PC).
- `DEPTH`, 2, entries per channel FIFO (≥1, any integer).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `i_drive` in NUM_CH: per-channel request valid.
- `i_data` in NUM_CH*DATA_W: channel c at bits [c*DATA_W +: DATA_W].
- `o_free` out NUM_CH: channel c can accept (ready).
- `o_drive0` out 1: table-update destination valid (zero requests).
- `o_data0` out DATA_W: table-update payload.
- `i_freeNext0` in 1: table-update destination ready.
- `o_drive1` out 1: correction destination valid (non-zero requests).
- `o_data1` out DATA_W: correction payload.
- `i_freeNext1` in 1: correction destination ready.
- `o_grant` out NUM_CH: one-hot, pulses the cycle channel c's head is dequeued.

## Operation
- Input transfer on channel c: `i_drive[c] & o_free[c]` at a rising edge; `o_free[c] = (count[c] < DEPTH)`, no same-cycle bypass when full (a full FIFO refuses even while dequeuing).
- `i_drive[c]` while `o_free[c]`=0 is ignored (producer holds).
- Route of a head entry: destination 0 if head == 0, else destination 1.
- Output stage: one register per destination. Register d can load this cycle when it is empty or `o_driveD & i_freeNextD` (drain-and-refill allowed).
- Eligible channel: FIFO non-empty and its head's destination register can load this cycle.
- Arbiter grants at most one eligible channel per cycle (aggregate throughput 1 request/cycle); granted head pops and loads its destination register at the same edge; `o_grant` is combinational for that cycle.
- Output transfer: `o_driveD & i_freeNextD` at an edge; `o_driveD`/`o_dataD` held stable until then.
- Non-eligible heads do not block other channels (no head-of-line blocking across channels; in-channel order preserved).
- FIFO pointers wrap modulo DEPTH; count width clog2(DEPTH+1).

## Timing
- Reset (rst low, asynchronous): all FIFOs empty, both output registers invalid, `o_drive0/1`=0, `o_data0/1`=0, `o_grant`=0, `o_free`=0 while rst low, round-robin pointer = 0. Mid-operation reset drops all buffered requests.
- First cycle after release: `o_free` = all ones.
- Latency: request accepted at edge k is eligible in cycle k+1; if granted, `o_driveD` high after edge k+1 (1 cycle minimum).
- Simultaneous enqueue and dequeue on one channel: count unchanged, both take effect.
- Downstream stall (`i_freeNextD`=0 with register full): channels whose head targets D stall; others proceed.

## Configuration
- `B_REDIRECT_RR_EN` defined: round-robin arbitration; pointer advances to (granted index + 1) mod NUM_CH after each grant, search starts at pointer.
- Undefined: fixed priority, lowest eligible index wins; pointer logic absent.

## Test plan
- Reset then single request ch1 data 0x0_0000_1000 -> `o_drive1`=1 with that data one cycle after accept edge, `o_grant`=0b10 in the grant cycle, `o_drive0` stays 0.
- ch0 data 0 with `i_freeNext0`=1 -> `o_drive0`=1, `o_data0`=0, held one cycle, then 0.
- `i_freeNext1`=0, push DEPTH+1 non-zero requests on ch0 -> output holds first, FIFO fills, `o_free[0]`=0 after DEPTH+1 accepted (1 in register + DEPTH buffered); ch1 zero request still reaches `o_drive0`.
- Both channels continuously non-empty, both destinations ready: fixed-priority build grants ch0 every cycle; `B_REDIRECT_RR_EN` build alternates grants 01,10,01,10.
- Full ch0 FIFO, `i_drive[0]`=1 same cycle as pop -> no accept that cycle, accept next cycle; in-order output verified.
- Assert rst low with 3 buffered requests and `o_drive1`=1 -> outputs 0 immediately, after release no stale request emerges.
